// File: rtl/palette_pkg.sv
// Shared types and constants for the runtime-writable palette lookup.
package palette_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int TRANSPARENT_IDX = 0;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [23:0] FLASH_COLOR_DEFAULT = 24'hFFFFFF;

endpackage

// File: rtl/palette_flash_ctr.sv
// Per-palette frame-counted flash timer: a load restarts it, each frame tick
// counts it down to zero; odd counts are the flash "on" phase.
module palette_flash_ctr #(
  parameter int FLASH_FRAMES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic tick,
  output logic active,
  output logic odd
);

  logic [7:0] cnt;

  // A load in the same cycle as a frame tick takes priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= 8'(FLASH_FRAMES);
    end else if (tick && cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign active = (cnt != 8'd0);
  assign odd    = cnt[0];

endmodule

// File: rtl/palette_bank.sv
// Multi-palette colour lookup: boot-time clear, runtime entry writes,
// 2-cycle pixel lookup with transparent index 0 and per-palette flash.
module palette_bank
  import palette_pkg::*;
#(
  parameter int          NUM_PAL      = 4,
  parameter int          IDX_W        = 4,
  parameter int          FLASH_FRAMES = 8,
  parameter logic [23:0] FLASH_COLOR  = FLASH_COLOR_DEFAULT,
  localparam int         PAL_W        = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_frame_start,
  input  logic               i_valid,
  input  logic [PAL_W-1:0]   i_pal_sel,
  input  logic [IDX_W-1:0]   i_idx,
  output logic               o_valid,
  output logic [23:0]        o_color,
  output logic               o_opaque,
  input  logic               i_wr_en,
  input  logic [PAL_W-1:0]   i_wr_pal,
  input  logic [IDX_W-1:0]   i_wr_idx,
  input  logic [23:0]        i_wr_color,
  output logic               o_wr_ready,
  input  logic [NUM_PAL-1:0] i_flash_trig,
  output logic [NUM_PAL-1:0] o_flash_active,
  output state_t             o_state
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam int DEPTH   = NUM_PAL * ENTRIES;
  localparam int AW      = PAL_W + IDX_W;
  localparam logic [AW-1:0]  LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [PAL_W:0] NUM_PAL_L = (PAL_W + 1)'(NUM_PAL);

  // ---------------- clear sequencer FSM ----------------
  state_t        state, state_nxt;
  logic [AW-1:0] clr_addr;
  logic          clr_we;
  logic          wr_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= INIT;
      clr_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) begin
        clr_addr <= clr_addr + AW'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (clr_addr == LAST_ADDR) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  always_comb begin
    clr_we   = (state == INIT);
    wr_ready = (state == RUN);
  end

  assign o_wr_ready = wr_ready;
  assign o_state    = state;

  // ---------------- RAM write port ----------------
  // Write handshake: an entry is written on a clock edge where i_wr_en and
  // o_wr_ready are both high; with o_wr_ready low the request is discarded,
  // never held, and out-of-range palettes are discarded too.
  logic          wr_in_range;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  rgb_t          ram_wdata;

  assign wr_in_range = ({1'b0, i_wr_pal} < NUM_PAL_L);

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    if (clr_we) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr;
    end else if (i_wr_en && wr_ready && wr_in_range) begin
      ram_we    = 1'b1;
      ram_waddr = {i_wr_pal, i_wr_idx};
      ram_wdata = i_wr_color;
    end
  end

  // ---------------- stage 1: RAM read + sideband ----------------
  rgb_t          ram [DEPTH];
  rgb_t          rd_data;
  logic [AW-1:0] rd_addr;
  logic          rd_in_range;

  assign rd_in_range = ({1'b0, i_pal_sel} < NUM_PAL_L);
  assign rd_addr     = rd_in_range ? {i_pal_sel, i_idx} : '0;

  // Read-before-write: a same-address collision returns the old entry.
  always_ff @(posedge i_clk) begin
    if (ram_we) begin
      ram[ram_waddr] <= ram_wdata;
    end
    rd_data <= ram[rd_addr];
  end

  logic             s1_valid;
  logic             s1_idx_nz;
  logic [PAL_W-1:0] s1_pal;
  logic             s1_in_range;
  logic             s1_run;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid    <= 1'b0;
      s1_idx_nz   <= 1'b0;
      s1_pal      <= '0;
      s1_in_range <= 1'b0;
      s1_run      <= 1'b0;
    end else begin
      s1_valid    <= i_valid;
      s1_idx_nz   <= (i_idx != IDX_W'(TRANSPARENT_IDX));
      s1_pal      <= i_pal_sel;
      s1_in_range <= rd_in_range;
      s1_run      <= (state == RUN);
    end
  end

  // ---------------- flash counters ----------------
  logic [NUM_PAL-1:0] flash_odd;

  for (genvar p = 0; p < NUM_PAL; p++) begin : g_flash
    palette_flash_ctr #(
      .FLASH_FRAMES(FLASH_FRAMES)
    ) u_ctr (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .load  (i_flash_trig[p]),
      .tick  (i_frame_start),
      .active(o_flash_active[p]),
      .odd   (flash_odd[p])
    );
  end

  logic sel_odd;

  always_comb begin
    sel_odd = 1'b0;
    for (int p = 0; p < NUM_PAL; p++) begin
      if (s1_pal == PAL_W'(p)) sel_odd = flash_odd[p];
    end
  end

  // ---------------- stage 2: output formation ----------------
  logic s2_opaque;

  assign s2_opaque = s1_valid && s1_idx_nz && s1_in_range && s1_run;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_valid  <= 1'b0;
      o_opaque <= 1'b0;
      o_color  <= '0;
    end else begin
      o_valid  <= s1_valid;
      o_opaque <= s2_opaque;
      if (!s2_opaque)   o_color <= '0;
      else if (sel_odd) o_color <= FLASH_COLOR;
      else              o_color <= rd_data;
    end
  end

endmodule

// File: tb/tb_palette_bank.sv
// Bench for palette_bank: behavioural model + per-cycle compare, directed
// vectors with literal expectations, and a 5-palette instance for range cases.
module tb_palette_bank;
  import palette_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (4 palettes) ----------------
  logic        rst_n;
  logic        frame_start, valid, wr_en;
  logic [1:0]  pal_sel, wr_pal;
  logic [3:0]  idx, wr_idx;
  logic [23:0] wr_color;
  logic [3:0]  flash_trig;
  logic        o_valid, o_opaque, o_wr_ready;
  logic [23:0] o_color;
  logic [3:0]  o_flash_active;
  state_t      o_state;

  palette_bank #(.NUM_PAL(4), .IDX_W(4), .FLASH_FRAMES(8), .FLASH_COLOR(24'hFFFFFF)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(frame_start),
    .i_valid(valid), .i_pal_sel(pal_sel), .i_idx(idx),
    .o_valid(o_valid), .o_color(o_color), .o_opaque(o_opaque),
    .i_wr_en(wr_en), .i_wr_pal(wr_pal), .i_wr_idx(wr_idx), .i_wr_color(wr_color),
    .o_wr_ready(o_wr_ready), .i_flash_trig(flash_trig),
    .o_flash_active(o_flash_active), .o_state(o_state)
  );

  // ---------------- second DUT (5 palettes) ----------------
  logic        b_frame, b_valid, b_wr_en;
  logic [2:0]  b_pal, b_wr_pal;
  logic [3:0]  b_idx, b_wr_idx;
  logic [23:0] b_wr_color;
  logic [4:0]  b_trig;
  logic        b_o_valid, b_o_opaque, b_o_wr_ready;
  logic [23:0] b_o_color;
  logic [4:0]  b_o_flash_active;
  state_t      b_o_state;

  palette_bank #(.NUM_PAL(5), .IDX_W(4), .FLASH_FRAMES(8), .FLASH_COLOR(24'hFFFFFF)) dut5 (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(b_frame),
    .i_valid(b_valid), .i_pal_sel(b_pal), .i_idx(b_idx),
    .o_valid(b_o_valid), .o_color(b_o_color), .o_opaque(b_o_opaque),
    .i_wr_en(b_wr_en), .i_wr_pal(b_wr_pal), .i_wr_idx(b_wr_idx), .i_wr_color(b_wr_color),
    .o_wr_ready(b_o_wr_ready), .i_flash_trig(b_trig),
    .o_flash_active(b_o_flash_active), .o_state(b_o_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: entries, flash counts and cycles since reset; a lookup's result is
  // fixed at request time except for the flash phase, taken one edge later.
  logic [25:0] exp_q[$];
  int          m_cyc;
  int          m_fl[4];
  logic [23:0] m_mem[64];
  logic        pend_v, pend_o;
  logic [1:0]  pend_pal;
  logic [23:0] pend_d;
  bit          live = 1'b0;
  logic [25:0] cmp_e;
  logic [3:0]  cmp_fl;

  always @(posedge clk) begin
    live = 1'b1;
    if (!rst_n) begin
      m_cyc = 0;
      for (int p = 0; p < 4; p++) m_fl[p] = 0;
      pend_v = 1'b0;
      pend_o = 1'b0;
      exp_q.push_back(26'h0);
    end else begin
      exp_q.push_back({pend_v, pend_o,
                       pend_o ? ((m_fl[pend_pal] % 2 == 1) ? 24'hFFFFFF : pend_d) : 24'h0});
      pend_v   = valid;
      pend_o   = valid && (idx != 4'd0) && (m_cyc >= 64);
      pend_pal = pal_sel;
      pend_d   = m_mem[{pal_sel, idx}];
      if (m_cyc < 64) m_mem[m_cyc] = 24'h0;
      else if (wr_en) m_mem[{wr_pal, wr_idx}] = wr_color;
      for (int p = 0; p < 4; p++) begin
        if (flash_trig[p]) m_fl[p] = 8;
        else if (frame_start && m_fl[p] > 0) m_fl[p] = m_fl[p] - 1;
      end
      if (m_cyc < 64) m_cyc++;
    end
  end

  always @(negedge clk) begin
    if (live) begin
      if (exp_q.size() == 0) begin
        chk("cmp_queue_empty", 32'd0, 32'd1);
      end else begin
        cmp_e = exp_q.pop_front();
        chk("cmp_valid", o_valid, cmp_e[25]);
        chk("cmp_opaque", o_opaque, cmp_e[24]);
        chk("cmp_color", o_color, cmp_e[23:0]);
      end
      chk("cmp_wr_ready", o_wr_ready, m_cyc >= 64);
      chk("cmp_state", o_state, (m_cyc >= 64) ? 32'd1 : 32'd0);
      for (int p = 0; p < 4; p++) cmp_fl[p] = (m_fl[p] != 0);
      chk("cmp_flash_active", o_flash_active, cmp_fl);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wr(input logic [1:0] p, input logic [3:0] x, input logic [23:0] c);
    wr_en = 1'b1; wr_pal = p; wr_idx = x; wr_color = c;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic lookup(input logic [1:0] p, input logic [3:0] x, input logic [23:0] ec,
                        input logic eo, input string nm);
    valid = 1'b1; pal_sel = p; idx = x;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    chk({nm, "_valid"}, o_valid, 32'd1);
    chk({nm, "_color"}, o_color, ec);
    chk({nm, "_opaque"}, o_opaque, eo);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic trig(input logic [3:0] t, input logic with_frame);
    flash_trig = t; frame_start = with_frame;
    @(negedge clk);
    flash_trig = '0; frame_start = 1'b0;
  endtask

  task automatic b_wr(input logic [2:0] p, input logic [3:0] x, input logic [23:0] c);
    b_wr_en = 1'b1; b_wr_pal = p; b_wr_idx = x; b_wr_color = c;
    @(negedge clk);
    b_wr_en = 1'b0;
  endtask

  task automatic b_lookup(input logic [2:0] p, input logic [3:0] x, input logic [23:0] ec,
                          input logic eo, input string nm);
    b_valid = 1'b1; b_pal = p; b_idx = x;
    @(negedge clk);
    b_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_valid"}, b_o_valid, 32'd1);
    chk({nm, "_color"}, b_o_color, ec);
    chk({nm, "_opaque"}, b_o_opaque, eo);
  endtask

  // ---------------- directed sequence ----------------
  int n;

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; valid = 1'b0; wr_en = 1'b0;
    pal_sel = '0; idx = '0; wr_pal = '0; wr_idx = '0; wr_color = '0; flash_trig = '0;
    b_frame = 1'b0; b_valid = 1'b0; b_wr_en = 1'b0; b_pal = '0; b_idx = '0;
    b_wr_pal = '0; b_wr_idx = '0; b_wr_color = '0; b_trig = '0;

    repeat (3) @(negedge clk);
    chk("rst_valid", o_valid, 32'd0);
    chk("rst_color", o_color, 32'd0);
    chk("rst_opaque", o_opaque, 32'd0);
    chk("rst_wr_ready", o_wr_ready, 32'd0);
    chk("rst_flash", o_flash_active, 32'd0);
    rst_n = 1'b1;

    // INIT: a lookup comes out transparent, a write to an already-cleared entry is dropped
    n = 0;
    while (o_wr_ready !== 1'b1 && n < 200) begin
      valid = (n == 5); pal_sel = 2'd1; idx = 4'd5;
      wr_en = (n == 20); wr_pal = 2'd0; wr_idx = 4'd1; wr_color = 24'h55aa55;
      @(negedge clk);
      n++;
      if (n == 7) begin
        chk("init_lk_valid", o_valid, 32'd1);
        chk("init_lk_opaque", o_opaque, 32'd0);
        chk("init_lk_color", o_color, 32'd0);
      end
    end
    valid = 1'b0; wr_en = 1'b0;
    chk("init_len", n, 32'd64);

    wr(2'd2, 4'd5, 24'h7fbf46);
    lookup(2'd2, 4'd5, 24'h7fbf46, 1'b1, "lk_2_5");
    wr(2'd2, 4'd0, 24'h123456);
    lookup(2'd2, 4'd0, 24'h0, 1'b0, "lk_2_0");
    lookup(2'd0, 4'd1, 24'h0, 1'b1, "init_wr_dropped");

    // same-cycle write/read of (1,3), then a read the next cycle
    wr_en = 1'b1; wr_pal = 2'd1; wr_idx = 4'd3; wr_color = 24'hdf51fd;
    valid = 1'b1; pal_sel = 2'd1; idx = 4'd3;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    valid = 1'b0;
    chk("coll_old_color", o_color, 32'd0);
    chk("coll_old_opaque", o_opaque, 32'd1);
    @(negedge clk);
    chk("coll_new_color", o_color, 32'hdf51fd);

    // flash on palette 1 over 8 frames; palette 0 unaffected
    wr(2'd1, 4'd7, 24'h00a0b0);
    wr(2'd0, 4'd4, 24'h3c3c3c);
    trig(4'b0010, 1'b0);
    chk("flash_rise", o_flash_active, 32'h2);
    lookup(2'd1, 4'd7, 24'h00a0b0, 1'b1, "flash_cnt8");
    for (int k = 1; k <= 8; k++) begin
      frames(1);
      chk("flash_active1", o_flash_active[1], (k < 8) ? 32'd1 : 32'd0);
      lookup(2'd1, 4'd7, ((8 - k) % 2 == 1) ? 24'hFFFFFF : 24'h00a0b0, 1'b1, "flash_p1");
      lookup(2'd0, 4'd4, 24'h3c3c3c, 1'b1, "flash_p0");
    end

    // trigger and frame_start together mid-flash: the reload wins
    trig(4'b0010, 1'b0);
    frames(2);
    trig(4'b0010, 1'b1);
    frames(7);
    chk("reload_active_after7", o_flash_active[1], 32'd1);
    lookup(2'd1, 4'd7, 24'hFFFFFF, 1'b1, "reload_cnt1");
    frames(1);
    chk("reload_active_after8", o_flash_active[1], 32'd0);

    // reset in mid-stream
    trig(4'b0100, 1'b0);
    valid = 1'b1; pal_sel = 2'd2; idx = 4'd5;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", o_valid, 32'd0);
    chk("mid_rst_color", o_color, 32'd0);
    chk("mid_rst_opaque", o_opaque, 32'd0);
    chk("mid_rst_wr_ready", o_wr_ready, 32'd0);
    chk("mid_rst_flash", o_flash_active, 32'd0);
    rst_n = 1'b1; valid = 1'b0;
    n = 0;
    while (o_wr_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reinit_len", n, 32'd64);
    while (b_o_wr_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("b_init_len", n, 32'd80);
    lookup(2'd2, 4'd5, 24'h0, 1'b1, "reinit_cleared");

    // 5-palette instance: palette 5 is out of range
    b_wr(3'd5, 4'd3, 24'habcdef);
    b_wr(3'd4, 4'd3, 24'h112233);
    b_lookup(3'd5, 4'd3, 24'h0, 1'b0, "b_oor_pal5");
    b_lookup(3'd4, 4'd3, 24'h112233, 1'b1, "b_pal4");
    b_lookup(3'd0, 4'd3, 24'h0, 1'b1, "b_pal0_noalias");
    b_lookup(3'd1, 4'd3, 24'h0, 1'b1, "b_pal1_noalias");

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
